sprite_line_renderer: RTL and testbench
=======================================

SPRITE_LINE_RENDERER -- requirements
Module: sprite_line_renderer

Interface
REQ-001 SHALL have parameter H_TILES, default 40: tiles per scanline.
REQ-002 SHALL have parameter TILE_W, default 16: pixels per tile line, equal to the get_data width.
REQ-003 SHALL have one clock and asynchronous active-high reset: CLK_100 input 1, rising-edge clock; RESET input 1, asynchronous active-high reset.
REQ-004 SHALL have the following control and tile-map ports:
- line_start  input  1  one-cycle pulse at the start of horizontal blanking
- fetch_y  input  10  scanline to prefetch; sampled on line_start
- tile_col  output  6  tile-map column address
- tile_row  output  5  tile-map row address
- tile_index  input  8  tile-map data; valid 1 cycle after tile_col/tile_row
REQ-005 SHALL have the following sprite RAM ports:
- get_index  output  8  sprite index to sprite RAM
- get_line  output  4  sprite row to sprite RAM
- get_data  input  16  sprite line; valid 1 cycle after get_index/get_line; bit 15 is the leftmost pixel
REQ-006 SHALL have the following display-side ports:
- DrawX  input  10  current display pixel column
- pixel_on  output  1  foreground bit for DrawX; 1-cycle latency
- busy  output  1  high while a fetch is in progress
- overrun  output  1  sticky; set when a line_start arrives during a fetch

Function
REQ-007 SHALL hold two H_TILES*TILE_W-bit line buffers: front, read by the display, and back, written by the fetch.
REQ-008 SHALL on line_start swap front and back, capture fetch_y, and enter FETCH.
REQ-009 FSM SHALL have states IDLE, FETCH, DRAIN. FETCH lasts H_TILES cycles; DRAIN lasts 2 cycles; the FSM then returns to IDLE.
REQ-010 In FETCH, cycle k SHALL drive tile_col=k and tile_row=fetch_y[8:4].
REQ-011 At cycle k+1 the block SHALL drive get_index=tile_index and get_line=fetch_y[3:0].
REQ-012 At cycle k+2 the block SHALL write get_data into back[k*16 +: 16], with get_data bit 15 mapped to pixel column k*16.
REQ-013 The fetch pipeline SHALL sustain one tile per cycle. A full line SHALL complete in H_TILES+2 cycles after line_start (42 at default).
REQ-014 busy SHALL be high from the cycle after line_start until DRAIN completes.
REQ-015 If fetch_y >= 480, the block SHALL still run the full sequence, write zeros into every back-buffer slot, and hold tile_col/tile_row/get_index/get_line at 0.
REQ-016 line_start during FETCH or DRAIN SHALL:
- abandon in-flight writes
- swap buffers
- restart at column 0 with the new fetch_y
- set overrun
REQ-017 pixel_on SHALL be registered as front[DrawX] when DrawX < H_TILES*TILE_W, and 0 otherwise.
REQ-018 A swap SHALL take effect for pixel_on on the cycle after line_start, with no mixed-buffer output within a cycle.
REQ-019 Column counter SHALL be 6 bits. It SHALL stop at H_TILES-1 and SHALL never wrap into column 0 within one fetch.

Reset
REQ-020 RESET SHALL asynchronously force:
- FSM to IDLE
- column counter to 0
- busy=0, overrun=0, pixel_on=0
- tile_col, tile_row, get_index, get_line all 0
- front-buffer select to buffer 0
REQ-021 Line-buffer contents SHALL be cleared to 0 by reset.
REQ-022 RESET asserted mid-FETCH SHALL suppress all further back-buffer writes from that fetch.

Structure
REQ-023 A shared package sprite_pkg SHALL hold:
- H_TILES, TILE_W, SCREEN_W=640, SCREEN_H=480
- the render FSM state enum
REQ-024 A single sub-module, line_buffer, SHALL implement one write-16/read-1 buffer and be instantiated twice.

Verification
REQ-025 Tile map all 8'h01, sprite 1 line 7 = 16'hF00F, line_start with fetch_y=7: after 42 cycles busy=0; next line_start; DrawX=0..3 gives pixel_on=1; DrawX=4..11 gives 0.
REQ-026 Tile map index = column number: get_index sequence 0..39 on consecutive cycles, get_line constant = fetch_y[3:0].
REQ-027 fetch_y=500: no nonzero get_index; after swap, pixel_on=0 for all DrawX.
REQ-028 Second line_start 20 cycles after the first: overrun=1, fetch restarts at tile_col=0, and overrun stays 1 until RESET.
REQ-029 RESET asserted at FETCH cycle 10: busy=0 and tile_col=0 immediately; after release, pixel_on=0 everywhere.
REQ-030 DrawX=640..1023: pixel_on=0 regardless of buffer contents.

Source files
------------

// File: rtl/sprite_pkg.sv
// sprite_pkg: constants and types shared by the sprite line renderer.
//   H_TILES  - tiles per scanline
//   TILE_W   - pixels per tile line (one sprite RAM word)
//   SCREEN_W - visible pixels per scanline
//   SCREEN_H - visible scanlines; fetches at or beyond this row render blank
//   render_state_t - render FSM states
package sprite_pkg;

    localparam int H_TILES  = 40;
    localparam int TILE_W   = 16;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN
    } render_state_t;

endpackage

// File: rtl/sprite_line_renderer_if.sv
// sprite_line_renderer_if: tile-map and sprite RAM bus of the line renderer.
//   tile_col/tile_row   - tile-map address (renderer -> tile map)
//   tile_index          - tile-map data, one cycle after the address
//   get_index/get_line  - sprite RAM address (renderer -> sprite RAM)
//   get_data            - sprite line, one cycle after the address; bit 15 is leftmost
// master: renderer side.  slave: memory side.
interface sprite_line_renderer_if;

    logic [5:0]  tile_col;
    logic [4:0]  tile_row;
    logic [7:0]  tile_index;
    logic [7:0]  get_index;
    logic [3:0]  get_line;
    logic [15:0] get_data;

    modport master (
        output tile_col, tile_row, get_index, get_line,
        input  tile_index, get_data
    );

    modport slave (
        input  tile_col, tile_row, get_index, get_line,
        output tile_index, get_data
    );

endinterface

// File: rtl/line_buffer.sv
// line_buffer: one scanline of foreground bits, written a tile word at a time
// and read one pixel at a time.
//   clk, rst - clock, asynchronous active-high reset (clears all contents)
//   wr_en    - write wr_data into tile slot wr_col
//   wr_col   - tile slot to write
//   wr_data  - tile line, bit TILE_W-1 is the leftmost pixel of the slot
//   rd_x     - pixel column to read
//   rd_bit   - combinational pixel value; 0 for columns past the last tile
module line_buffer #(
    parameter int H_TILES = sprite_pkg::H_TILES,
    parameter int TILE_W  = sprite_pkg::TILE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [5:0]        wr_col,
    input  logic [TILE_W-1:0] wr_data,
    input  logic [9:0]        rd_x,
    output logic              rd_bit
);

    localparam logic [5:0] LAST_COL = 6'(H_TILES - 1);

    logic [TILE_W-1:0] mem [H_TILES];
    logic [5:0]        rd_word;
    logic [3:0]        rd_pix;

    // NOTE: the buffer must read back as blank after reset, so the array is
    // built from resettable flops rather than an inferred RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < H_TILES; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_col] <= wr_data;
        end
    end

    assign rd_word = rd_x[9:4];
    assign rd_pix  = rd_x[3:0];

    // Leftmost pixel of a slot lives in the MSB, hence the inverted bit index.
    assign rd_bit = (rd_word <= LAST_COL) ? mem[rd_word][~rd_pix] : 1'b0;

endmodule

// File: rtl/sprite_line_renderer.sv
// sprite_line_renderer: prefetches one scanline of tile graphics into a back
// line buffer during horizontal blanking while the display reads the front one.
//   CLK_100, RESET - clock, asynchronous active-high reset
//   line_start     - one-cycle pulse: swap buffers and start fetching fetch_y
//   fetch_y        - scanline to prefetch, sampled on line_start
//   DrawX          - display pixel column
//   pixel_on       - registered foreground bit of the front buffer at DrawX
//   busy           - fetch or drain in progress
//   overrun        - sticky: line_start arrived while a fetch was in progress
//   bus            - tile-map / sprite RAM bus (master side)
module sprite_line_renderer #(
    parameter int H_TILES = sprite_pkg::H_TILES,
    parameter int TILE_W  = sprite_pkg::TILE_W
) (
    input  logic                          CLK_100,
    input  logic                          RESET,
    input  logic                          line_start,
    input  logic [9:0]                    fetch_y,
    input  logic [9:0]                    DrawX,
    output logic                          pixel_on,
    output logic                          busy,
    output logic                          overrun,
    sprite_line_renderer_if.master        bus
);

    localparam logic [5:0] LAST_COL = 6'(H_TILES - 1);
    localparam logic [9:0] LINE_PIX = 10'(H_TILES * TILE_W);
    localparam logic [9:0] Y_LIMIT  = 10'(sprite_pkg::SCREEN_H);

    sprite_pkg::render_state_t state, state_next;

    logic [5:0]        col;
    logic              drain_cnt;
    logic [8:0]        fy;
    logic              fy_ok;       // captured row is on screen
    logic              front_sel;   // 0: buffer 0 is displayed
    logic              v1, v2;      // pipeline valid: address issued / data arriving
    logic [5:0]        col1, col2;
    logic              wr_en;
    logic [TILE_W-1:0] wr_data;
    logic              rd0, rd1;

    // NOTE: every clocked block uses non-blocking assignments so all
    // registers update from the same pre-edge values.
    always_ff @(posedge CLK_100 or posedge RESET) begin
        if (RESET) state <= sprite_pkg::ST_IDLE;
        else       state <= state_next;
    end

    // NOTE: state_next is defaulted before the case so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        if (line_start) begin
            state_next = sprite_pkg::ST_FETCH;
        end else begin
            unique case (state)
                sprite_pkg::ST_IDLE:  state_next = sprite_pkg::ST_IDLE;
                sprite_pkg::ST_FETCH: if (col == LAST_COL) state_next = sprite_pkg::ST_DRAIN;
                sprite_pkg::ST_DRAIN: if (drain_cnt)       state_next = sprite_pkg::ST_IDLE;
                default:              state_next = sprite_pkg::ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK_100 or posedge RESET) begin
        if (RESET) begin
            col       <= '0;
            drain_cnt <= 1'b0;
            fy        <= '0;
            fy_ok     <= 1'b0;
            front_sel <= 1'b0;
            overrun   <= 1'b0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            col1      <= '0;
            col2      <= '0;
        end else if (line_start) begin
            // Swap and restart; anything still in the pipeline is dropped.
            front_sel <= ~front_sel;
            fy        <= fetch_y[8:0];
            fy_ok     <= (fetch_y < Y_LIMIT);
            col       <= '0;
            drain_cnt <= 1'b0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            if (state != sprite_pkg::ST_IDLE) overrun <= 1'b1;
        end else begin
            // Column saturates at the last tile instead of wrapping.
            if (state == sprite_pkg::ST_FETCH && col != LAST_COL) col <= col + 6'd1;
            drain_cnt <= (state == sprite_pkg::ST_DRAIN) && !drain_cnt;
            v1        <= (state == sprite_pkg::ST_FETCH);
            col1      <= col;
            v2        <= v1;
            col2      <= col1;
        end
    end

    // Off-screen rows keep the bus quiet and fill the back buffer with zeros.
    assign bus.tile_col  = (state == sprite_pkg::ST_FETCH && fy_ok) ? col      : '0;
    assign bus.tile_row  = (state == sprite_pkg::ST_FETCH && fy_ok) ? fy[8:4]  : '0;
    assign bus.get_index = (v1 && fy_ok) ? bus.tile_index : '0;
    assign bus.get_line  = (v1 && fy_ok) ? fy[3:0]        : '0;
    assign busy          = (state != sprite_pkg::ST_IDLE);

    // A write landing on the swap edge would hit the new front buffer.
    assign wr_en   = v2 && !line_start;
    assign wr_data = fy_ok ? bus.get_data : '0;

    line_buffer #(.H_TILES(H_TILES), .TILE_W(TILE_W)) u_buf0 (
        .clk     (CLK_100),
        .rst     (RESET),
        .wr_en   (wr_en && front_sel),
        .wr_col  (col2),
        .wr_data (wr_data),
        .rd_x    (DrawX),
        .rd_bit  (rd0)
    );

    line_buffer #(.H_TILES(H_TILES), .TILE_W(TILE_W)) u_buf1 (
        .clk     (CLK_100),
        .rst     (RESET),
        .wr_en   (wr_en && !front_sel),
        .wr_col  (col2),
        .wr_data (wr_data),
        .rd_x    (DrawX),
        .rd_bit  (rd1)
    );

    always_ff @(posedge CLK_100 or posedge RESET) begin
        if (RESET) pixel_on <= 1'b0;
        else       pixel_on <= (DrawX < LINE_PIX) && (front_sel ? rd1 : rd0);
    end

endmodule

// File: tb/tb_sprite_line_renderer.sv
// tb_sprite_line_renderer: directed self-checking bench for sprite_line_renderer.
// Tile map and sprite RAM are modelled as one-cycle-latency memories.
module tb_sprite_line_renderer;

    logic       CLK_100;
    logic       RESET;
    logic       line_start;
    logic [9:0] fetch_y;
    logic [9:0] DrawX;
    logic       pixel_on;
    logic       busy;
    logic       overrun;
    logic       tile_mode;   // 0: every tile is index 1, 1: tile index = column

    int checks = 0;
    int passes = 0;

    sprite_line_renderer_if bus ();

    sprite_line_renderer dut (
        .CLK_100    (CLK_100),
        .RESET      (RESET),
        .line_start (line_start),
        .fetch_y    (fetch_y),
        .DrawX      (DrawX),
        .pixel_on   (pixel_on),
        .busy       (busy),
        .overrun    (overrun),
        .bus        (bus.master)
    );

    initial CLK_100 = 1'b0;
    always #5 CLK_100 = ~CLK_100;

    function automatic logic [15:0] sprite_rom(input logic [7:0] idx, input logic [3:0] line);
        return (idx == 8'h01 && line == 4'd7) ? 16'hF00F : 16'h0000;
    endfunction

    always @(posedge CLK_100) begin
        bus.tile_index <= tile_mode ? {2'b00, bus.tile_col} : 8'h01;
        bus.get_data   <= sprite_rom(bus.get_index, bus.get_line);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Ends on the falling edge of the first cycle after line_start was sampled.
    task automatic pulse(input logic [9:0] y);
        @(negedge CLK_100);
        line_start = 1'b1;
        fetch_y    = y;
        @(negedge CLK_100);
        line_start = 1'b0;
    endtask

    task automatic check_pix(input int x, input logic exp);
        @(negedge CLK_100);
        DrawX = 10'(x);
        @(negedge CLK_100);
        check($sformatf("pix_%0d", x), 32'(pixel_on), 32'(exp));
    endtask

    task automatic scan_zero(input string tag);
        logic bad;
        bad = 1'b0;
        for (int x = 0; x < 640; x++) begin
            @(negedge CLK_100);
            DrawX = 10'(x);
            @(negedge CLK_100);
            if (pixel_on !== 1'b0) bad = 1'b1;
        end
        check(tag, 32'(bad), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic bad;
        RESET      = 1'b1;
        line_start = 1'b0;
        fetch_y    = '0;
        DrawX      = '0;
        tile_mode  = 1'b0;
        repeat (3) @(negedge CLK_100);

        // Reset state
        check("rst_busy",      32'(busy),          32'd0);
        check("rst_overrun",   32'(overrun),       32'd0);
        check("rst_pixel_on",  32'(pixel_on),      32'd0);
        check("rst_tile_col",  32'(bus.tile_col),  32'd0);
        check("rst_tile_row",  32'(bus.tile_row),  32'd0);
        check("rst_get_index", 32'(bus.get_index), 32'd0);
        check("rst_get_line",  32'(bus.get_line),  32'd0);
        RESET = 1'b0;

        // Full line with sprite 1 line 7 = F00F in every tile
        pulse(10'd7);
        check("f1_busy_c1",     32'(busy),          32'd1);
        check("f1_tile_col_c1", 32'(bus.tile_col),  32'd0);
        check("f1_tile_row_c1", 32'(bus.tile_row),  32'd0);
        @(negedge CLK_100);
        check("f1_get_index_c2", 32'(bus.get_index), 32'd1);
        check("f1_get_line_c2",  32'(bus.get_line),  32'd7);
        check("f1_tile_col_c2",  32'(bus.tile_col),  32'd1);
        repeat (40) @(negedge CLK_100);
        check("f1_busy_c42", 32'(busy), 32'd1);
        @(negedge CLK_100);
        check("f1_busy_c43", 32'(busy),    32'd0);
        check("f1_overrun",  32'(overrun), 32'd0);

        pulse(10'd7);
        for (int x = 0; x < 4; x++)  check_pix(x, 1'b1);
        for (int x = 4; x < 12; x++) check_pix(x, 1'b0);
        check_pix(12, 1'b1);
        check_pix(15, 1'b1);
        check_pix(16, 1'b1);
        check_pix(20, 1'b0);
        check_pix(639, 1'b1);
        // Past the visible line
        check_pix(640, 1'b0);
        check_pix(800, 1'b0);
        check_pix(1023, 1'b0);
        repeat (50) @(negedge CLK_100);

        // Off-screen row: bus stays at zero and the back buffer is blanked
        pulse(10'd500);
        bad = 1'b0;
        for (int i = 0; i < 44; i++) begin
            if (bus.get_index !== 8'd0 || bus.tile_col !== 6'd0 ||
                bus.tile_row !== 5'd0 || bus.get_line !== 4'd0) bad = 1'b1;
            @(negedge CLK_100);
        end
        check("y500_bus_quiet", 32'(bad),  32'd0);
        check("y500_busy_done", 32'(busy), 32'd0);
        pulse(10'd7);
        scan_zero("y500_front_blank");
        check("y500_overrun", 32'(overrun), 32'd0);
        repeat (50) @(negedge CLK_100);

        // Tile index equals column: get_index walks 0..39
        tile_mode = 1'b1;
        pulse(10'd37);
        check("seq_tile_row", 32'(bus.tile_row), 32'd2);
        check("seq_tile_col", 32'(bus.tile_col), 32'd0);
        bad = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK_100);
            check($sformatf("seq_get_index_%0d", k), 32'(bus.get_index), 32'(k));
            if (bus.get_line !== 4'd5) bad = 1'b1;
        end
        check("seq_get_line", 32'(bad),  32'd5 - 32'd5);
        check("seq_busy_c41", 32'(busy), 32'd1);
        repeat (10) @(negedge CLK_100);
        tile_mode = 1'b0;

        // Overrun: second line_start 20 cycles into a fetch
        pulse(10'd7);
        repeat (19) @(negedge CLK_100);
        check("ovr_before",      32'(overrun),      32'd0);
        check("ovr_tile_col_19", 32'(bus.tile_col), 32'd19);
        pulse(10'd7);
        check("ovr_set",         32'(overrun),      32'd1);
        check("ovr_restart_col", 32'(bus.tile_col), 32'd0);
        check("ovr_busy",        32'(busy),         32'd1);
        @(negedge CLK_100);
        check("ovr_next_col",    32'(bus.tile_col), 32'd1);
        repeat (60) @(negedge CLK_100);
        check("ovr_sticky_idle", 32'(overrun), 32'd1);
        check("ovr_busy_done",   32'(busy),    32'd0);
        pulse(10'd7);
        repeat (50) @(negedge CLK_100);
        check("ovr_sticky_more", 32'(overrun), 32'd1);

        // Reset in the middle of a fetch
        check_pix(0, 1'b1);
        pulse(10'd7);
        repeat (9) @(negedge CLK_100);
        check("mid_tile_col_pre", 32'(bus.tile_col), 32'd9);
        RESET = 1'b1;
        #1;
        check("mid_rst_busy",      32'(busy),          32'd0);
        check("mid_rst_tile_col",  32'(bus.tile_col),  32'd0);
        check("mid_rst_overrun",   32'(overrun),       32'd0);
        check("mid_rst_get_index", 32'(bus.get_index), 32'd0);
        check("mid_rst_pixel_on",  32'(pixel_on),      32'd0);
        repeat (2) @(negedge CLK_100);
        RESET = 1'b0;
        scan_zero("mid_rst_front0_blank");
        pulse(10'd500);
        scan_zero("mid_rst_front1_blank");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
